// File: rtl/tenkey_debounce.sv
// tenkey_debounce: synchronises and debounces the ten keypad switches and
// emits one single-cycle one-hot code per clean single-key press.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no key held; waiting for any synchronised switch activity
//   PRESS   | one candidate key seen; counting stable cycles to accept
//   HELD    | key accepted (or multi-key rejected); waiting for release
//   RELEASE | all keys up; counting stable cycles before re-arming
module tenkey_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] sw_raw,
    output logic [9:0] tenkey,
    output logic       key_valid,
    output logic       multi_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    // Terminal count; DEBOUNCE_CYCLES may equal 2^CNT_W, so the last count
    // always fits in CNT_W bits and the counter never needs to wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [9:0]       sw_m_q, sw_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       cand_q, cand_d;
    logic [9:0]       tenkey_q, tenkey_d;
    logic             key_valid_q, key_valid_d;
    logic             multi_err_q, multi_err_d;
    logic             busy_q, busy_d;

    // Next-state, counter, candidate and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        tenkey_d    = '0;
        key_valid_d = 1'b0;
        multi_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ($onehot(sw_s_q)) begin
                    cand_d  = sw_s_q;
                    cnt_d   = '0;
                    state_d = PRESS;
                end else if (sw_s_q != '0) begin
                    multi_err_d = 1'b1;
                    state_d     = HELD;
                end
            end
            PRESS: begin
                if (sw_s_q != cand_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    tenkey_d    = cand_q;
                    key_valid_d = 1'b1;
                    state_d     = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (sw_s_q == '0) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (sw_s_q != '0) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == HELD) || (state_d == RELEASE);
    end

    // Synchroniser, state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_m_q      <= '0;
            sw_s_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            tenkey_q    <= '0;
            key_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sw_m_q      <= sw_raw;
            sw_s_q      <= sw_m_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            tenkey_q    <= tenkey_d;
            key_valid_q <= key_valid_d;
            multi_err_q <= multi_err_d;
            busy_q      <= busy_d;
        end
    end

    assign tenkey    = tenkey_q;
    assign key_valid = key_valid_q;
    assign multi_err = multi_err_q;
    assign busy      = busy_q;

endmodule
